// File: rtl/poly_horner_eval_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : poly_horner_eval_pkg
//  Description : Shared state encoding and default sizing for the Horner
//                polynomial evaluator.
//  Revision    : 1.0 - initial release
// ============================================================================
package poly_horner_eval_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_X_W    = 8;
  localparam int DEF_DEG    = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/poly_mac.sv
`default_nettype none
// ============================================================================
//  Module      : poly_mac
//  Description : Combinational Horner step: acc*x + coef, evaluated at full
//                precision, returned wrapped to DATA_W with an overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module poly_mac #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] coef,
  output logic [DATA_W-1:0] sum,
  output logic              ovf
);

  // Full-width product plus addend; 2*DATA_W+1 bits cannot overflow.
  logic [2*DATA_W:0] full;

  // Multiply-add, then split into wrapped result and high-part overflow.
  always_comb begin
    full = ((2*DATA_W+1)'(acc) * (2*DATA_W+1)'(x)) + (2*DATA_W+1)'(coef);
    sum  = full[DATA_W-1:0];
    ovf  = |full[2*DATA_W:DATA_W];
  end

endmodule
`default_nettype wire

// File: rtl/poly_horner_eval.sv
`default_nettype none
// ============================================================================
//  Module      : poly_horner_eval
//  Description : Horner-method polynomial evaluator, one multiply-add per
//                clock, with an internal coefficient register file.
//  Revision    : 1.0 - initial release
// ============================================================================
module poly_horner_eval
  import poly_horner_eval_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int X_W    = DEF_X_W,
  parameter int DEG    = DEF_DEG,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [X_W-1:0]    x_in,
  input  logic              coef_we,
  input  logic [ADDR_W-1:0] coef_addr,
  input  logic [DATA_W-1:0] coef_data,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              overflow
);

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] coef_q [0:DEG];
  logic [DATA_W-1:0] acc;
  logic [X_W-1:0]    x_reg;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] mac_sum;
  logic              mac_ovf;
  logic              wr_ok;
  logic              accept;
  logic [DATA_W-1:0] top_coef;

  // Writes land only while idle and only inside the 0..DEG window.
  assign wr_ok  = (state == S_IDLE) && coef_we && (coef_addr <= ADDR_W'(DEG));
  assign accept = (state == S_IDLE) && start;

  // A same-edge write to the leading coefficient is forwarded into acc.
  assign top_coef = (wr_ok && (coef_addr == ADDR_W'(DEG))) ? coef_data : coef_q[DEG];

  assign result = acc;

  poly_mac #(
    .DATA_W (DATA_W)
  ) u_mac (
    .acc  (acc),
    .x    (DATA_W'(x_reg)),
    .coef (coef_q[idx]),
    .sum  (mac_sum),
    .ovf  (mac_ovf)
  );

  // Coefficient register file.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i <= DEG; i++) begin
        coef_q[i] <= '0;
      end
    end else if (wr_ok) begin
      coef_q[coef_addr] <= coef_data;
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          state_next = S_MAC;
        end
      end
      S_MAC: begin
        if (idx == '0) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Accumulator, sampled x, coefficient index and sticky overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc      <= '0;
      x_reg    <= '0;
      idx      <= '0;
      overflow <= 1'b0;
    end else if (accept) begin
      x_reg    <= x_in;
      acc      <= top_coef;
      idx      <= ADDR_W'(DEG - 1);
      overflow <= 1'b0;
    end else if (state == S_MAC) begin
      acc <= mac_sum;
      if (mac_ovf) begin
        overflow <= 1'b1;
      end
      if (idx != '0) begin
        idx <= idx - ADDR_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_poly_horner_eval.sv
`default_nettype none
// ============================================================================
//  Module      : tb_poly_horner_eval
//  Description : Self-checking bench for poly_horner_eval (DEG=2 and DEG=4
//                instances) against a plain-arithmetic polynomial model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_poly_horner_eval;

  logic        clock = 1'b0;
  logic        reset;

  // DEG=2 instance signals
  logic        start, coef_we, ready, done, overflow;
  logic [7:0]  x_in;
  logic [3:0]  coef_addr;
  logic [15:0] coef_data, result;

  // DEG=4 instance signals
  logic        d4_start, d4_coef_we, d4_ready, d4_done, d4_overflow;
  logic [7:0]  d4_x_in;
  logic [3:0]  d4_coef_addr;
  logic [15:0] d4_coef_data, d4_result;

  int total = 0;
  int bad   = 0;

  int unsigned mc2 [16];
  int unsigned mc4 [16];

  always #5 clock = ~clock;

  poly_horner_eval #(.DATA_W(16), .X_W(8), .DEG(2), .ADDR_W(4)) dut (
    .clock(clock), .reset(reset), .start(start), .x_in(x_in),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .ready(ready), .done(done), .result(result), .overflow(overflow)
  );

  poly_horner_eval #(.DATA_W(16), .X_W(8), .DEG(4), .ADDR_W(4)) dut4 (
    .clock(clock), .reset(reset), .start(d4_start), .x_in(d4_x_in),
    .coef_we(d4_coef_we), .coef_addr(d4_coef_addr), .coef_data(d4_coef_data),
    .ready(d4_ready), .done(d4_done), .result(d4_result), .overflow(d4_overflow)
  );

  // P(x) mod 2^16 as a sum of c[i]*x^i.
  function automatic logic [15:0] ref_result(input int deg, input int unsigned c [16], input int unsigned x);
    longint unsigned r = 0;
    longint unsigned p = 1;
    for (int i = 0; i <= deg; i++) begin
      r = (r + longint'(c[i]) * p) % 65536;
      p = (p * x) % 65536;
    end
    return r[15:0];
  endfunction

  // True if any nested step c[k+1..]*x + c[k] reaches 2^16 before wrapping.
  function automatic bit ref_ovf(input int deg, input int unsigned c [16], input int unsigned x);
    longint unsigned a = c[deg];
    longint unsigned f;
    bit o = 0;
    for (int i = deg - 1; i >= 0; i--) begin
      f = a * x + c[i];
      if (f >= 65536) o = 1;
      a = f % 65536;
    end
    return o;
  endfunction

  task automatic wr2(input logic [3:0] a, input logic [15:0] d);
    coef_we = 1'b1; coef_addr = a; coef_data = d;
    @(posedge clock); #1;
    coef_we = 1'b0;
  endtask

  task automatic wr4(input logic [3:0] a, input logic [15:0] d);
    d4_coef_we = 1'b1; d4_coef_addr = a; d4_coef_data = d;
    @(posedge clock); #1;
    d4_coef_we = 1'b0;
  endtask

  // Launch on the DEG=2 instance; lat = edges from acceptance to done, rlow = cycles ready was low.
  task automatic eval2(input logic [7:0] x, output logic [15:0] res, output logic ov, output int lat, output int rlow);
    bit got = 0;
    lat = -1; rlow = 0; res = 'x; ov = 'x;
    start = 1'b1; x_in = x;
    @(posedge clock); #1;
    start = 1'b0; x_in = 8'($urandom);
    if (!ready) rlow++;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(posedge clock); #1;
      x_in = 8'($urandom);
      if (!ready) rlow++;
      if (done) begin lat = k; got = 1; res = result; ov = overflow; end
    end
    @(posedge clock); #1;
    if (!ready) rlow++;
  endtask

  task automatic eval4(input logic [7:0] x, output logic [15:0] res, output logic ov, output int lat, output int rlow);
    bit got = 0;
    lat = -1; rlow = 0; res = 'x; ov = 'x;
    d4_start = 1'b1; d4_x_in = x;
    @(posedge clock); #1;
    d4_start = 1'b0; d4_x_in = 8'($urandom);
    if (!d4_ready) rlow++;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(posedge clock); #1;
      if (!d4_ready) rlow++;
      if (d4_done) begin lat = k; got = 1; res = d4_result; ov = d4_overflow; end
    end
    @(posedge clock); #1;
    if (!d4_ready) rlow++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    total++; if (ready !== 1'b1)     begin bad++; $display("FAIL reset_ready got=%b want=1", ready); end
    total++; if (done !== 1'b0)      begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (result !== 16'h0)   begin bad++; $display("FAIL reset_result got=%h want=0000", result); end
    total++; if (overflow !== 1'b0)  begin bad++; $display("FAIL reset_overflow got=%b want=0", overflow); end
    total++; if (d4_ready !== 1'b1 || d4_result !== 16'h0) begin bad++; $display("FAIL reset_d4 ready=%b result=%h want 1/0000", d4_ready, d4_result); end
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_basic();
    logic [15:0] r; logic o; int lat, rl;
    wr2(0, 5); wr2(1, 3); wr2(2, 2);
    mc2[0] = 5; mc2[1] = 3; mc2[2] = 2;
    eval2(4, r, o, lat, rl);
    total++; if (r !== 16'd49)  begin bad++; $display("FAIL basic_result got=%0d want=49", r); end
    total++; if (o !== 1'b0)    begin bad++; $display("FAIL basic_overflow got=%b want=0", o); end
    total++; if (lat !== 2)     begin bad++; $display("FAIL basic_latency got=%0d want=2", lat); end
    total++; if (rl !== 3)      begin bad++; $display("FAIL basic_ready_low got=%0d want=3", rl); end
  endtask

  task automatic test_overflow();
    logic [15:0] r; logic o; int lat, rl;
    wr2(2, 16'h0100); wr2(1, 16'h0100); wr2(0, 16'h0000);
    mc2[2] = 16'h100; mc2[1] = 16'h100; mc2[0] = 0;
    eval2(255, r, o, lat, rl);
    total++; if (r !== ref_result(2, mc2, 255) || r !== 16'h0) begin bad++; $display("FAIL ovf_result got=%h want=0000", r); end
    total++; if (o !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", o); end
    eval2(0, r, o, lat, rl);
    total++; if (r !== 16'h0) begin bad++; $display("FAIL ovf_x0_result got=%h want=0000", r); end
    total++; if (o !== 1'b0 || overflow !== 1'b0) begin bad++; $display("FAIL ovf_cleared got=%b/%b want=0", o, overflow); end
  endtask

  task automatic test_random();
    logic [15:0] r; logic o; int lat, rl; logic [7:0] x;
    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i <= 2; i++) begin
        mc2[i] = (n < 5) ? $urandom_range(0, 255) : $urandom_range(0, 65535);
        wr2(4'(i), 16'(mc2[i]));
      end
      if ($urandom_range(0, 1) == 1) wr2(4'($urandom_range(3, 15)), 16'($urandom));
      x = 8'($urandom);
      eval2(x, r, o, lat, rl);
      total++; if (r !== ref_result(2, mc2, x) || o !== ref_ovf(2, mc2, x) || lat !== 2)
        begin bad++; $display("FAIL random_%0d x=%0d got=%h/%b/%0d want=%h/%b/2", n, x, r, o, lat, ref_result(2, mc2, x), ref_ovf(2, mc2, x)); end
    end
  endtask

  task automatic test_busy();
    logic [15:0] r, rdone; logic o; int lat, rl; int pulses = 0;
    wr2(0, 5); wr2(1, 3); wr2(2, 2);
    mc2[0] = 5; mc2[1] = 3; mc2[2] = 2;
    rdone = 16'hDEAD;
    start = 1'b1; x_in = 4;
    @(posedge clock); #1;
    start = 1'b1; x_in = 8'd200;
    coef_we = 1'b1; coef_addr = 0; coef_data = 16'hFFFF;
    @(posedge clock); #1;
    start = 1'b0; coef_we = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (done) begin pulses++; rdone = result; end
      @(posedge clock); #1;
    end
    total++; if (pulses !== 1)      begin bad++; $display("FAIL busy_pulses got=%0d want=1", pulses); end
    total++; if (rdone !== 16'd49)  begin bad++; $display("FAIL busy_result got=%0d want=49", rdone); end
    eval2(4, r, o, lat, rl);
    total++; if (r !== ref_result(2, mc2, 4)) begin bad++; $display("FAIL busy_coef_kept got=%0d want=49", r); end
  endtask

  task automatic test_same_cycle();
    logic [15:0] r; int lat = -1; int rl = 0;
    start = 1'b1; x_in = 1;
    coef_we = 1'b1; coef_addr = 2; coef_data = 16'd10;
    mc2[2] = 10;
    @(posedge clock); #1;
    start = 1'b0; coef_we = 1'b0;
    r = 'x;
    for (int k = 1; k <= 10 && lat < 0; k++) begin
      @(posedge clock); #1;
      if (done) begin lat = k; r = result; end
    end
    @(posedge clock); #1;
    total++; if (r !== ref_result(2, mc2, 1) || lat !== 2) begin bad++; $display("FAIL same_cycle got=%0d lat=%0d want=18 lat=2", r, lat); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] r; logic o; int lat, rl; int pulses = 0; logic [7:0] x;
    start = 1'b1; x_in = 3;
    @(posedge clock); #1;
    start = 1'b0; reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    total++; if (ready !== 1'b1 || result !== 16'h0 || overflow !== 1'b0)
      begin bad++; $display("FAIL resetmid_state ready=%b result=%h ovf=%b want 1/0000/0", ready, result, overflow); end
    for (int k = 0; k < 6; k++) begin
      if (done) pulses++;
      @(posedge clock); #1;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL resetmid_done got=%0d want=0", pulses); end
    for (int i = 0; i < 16; i++) begin mc2[i] = 0; mc4[i] = 0; end
    x = 8'($urandom_range(1, 255));
    eval2(x, r, o, lat, rl);
    total++; if (r !== ref_result(2, mc2, x)) begin bad++; $display("FAIL resetmid_cleared got=%h want=0000", r); end
  endtask

  task automatic test_deg4();
    logic [15:0] r; logic o; int lat, rl; logic [7:0] x;
    for (int i = 0; i <= 4; i++) begin wr4(4'(i), 1); mc4[i] = 1; end
    wr4(5, 16'h7777);
    eval4(2, r, o, lat, rl);
    total++; if (r !== 16'd31 || r !== ref_result(4, mc4, 2)) begin bad++; $display("FAIL deg4_result got=%0d want=31", r); end
    total++; if (lat !== 4 || rl !== 5) begin bad++; $display("FAIL deg4_latency got=%0d/%0d want=4/5", lat, rl); end
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i <= 4; i++) begin mc4[i] = $urandom_range(0, 65535); wr4(4'(i), 16'(mc4[i])); end
      x = 8'($urandom);
      eval4(x, r, o, lat, rl);
      total++; if (r !== ref_result(4, mc4, x) || o !== ref_ovf(4, mc4, x))
        begin bad++; $display("FAIL deg4_random_%0d x=%0d got=%h/%b want=%h/%b", n, x, r, o, ref_result(4, mc4, x), ref_ovf(4, mc4, x)); end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 0; x_in = 0; coef_we = 0; coef_addr = 0; coef_data = 0;
    d4_start = 0; d4_x_in = 0; d4_coef_we = 0; d4_coef_addr = 0; d4_coef_data = 0;
    for (int i = 0; i < 16; i++) begin mc2[i] = 0; mc4[i] = 0; end
    test_reset();
    test_basic();
    test_overflow();
    test_random();
    test_busy();
    test_same_cycle();
    test_reset_mid();
    test_deg4();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
